// File: rtl/audio_src_if.sv
// audio_src_if: valid/ready handshake carrying one audio sample from a source to the scheduler.
interface audio_src_if #(parameter int DATA_W = 16);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;
    modport master (output valid, data, input ready);
    modport slave (input valid, data, output ready);
endinterface

// File: rtl/audio_src_scheduler.sv
// audio_src_scheduler: frame-synchronous round-robin sample scheduler for the PT8211 DAC driver.
// Optional SOFT_MUTE_EN macro ramps mute attenuation over 16 frames instead of hard muting.
module audio_src_scheduler #(
    parameter int FRAME_CYCLES = 128,
    parameter int DATA_W       = 16,
    parameter bit HOLD_LAST    = 1'b1
) (
    input  logic              clk_27mhz,
    input  logic              reset,
    input  logic              enable,
    input  logic              mute,
    audio_src_if.slave        src0,
    audio_src_if.slave        src1,
    output logic [DATA_W-1:0] audio_data_out,
    output logic              frame_tick,
    output logic [1:0]        grant,
    output logic [15:0]       underrun_cnt
);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] FETCH_CNT = CW'(FRAME_CYCLES - 2);
    localparam logic [CW-1:0] LOAD_CNT  = CW'(FRAME_CYCLES - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic              pref;
    logic [DATA_W-1:0] staging, out_n;
    logic [1:0]        fetch_grant;
    logic              active, fetch, load, g0, g1;

    always_ff @(posedge clk_27mhz) state <= reset ? IDLE : state_n;

    // pref=1 means src1 wins a tie; it flips only on a real grant
    always_comb begin
        state_n = enable ? RUN : IDLE;
        active  = (state == RUN) && enable;
        fetch   = active && (cnt == FETCH_CNT);
        load    = active && (cnt == LOAD_CNT);
        g0      = fetch && src0.valid && (!src1.valid || !pref);
        g1      = fetch && src1.valid && (!src0.valid || pref);
    end

    assign src0.ready = g0;
    assign src1.ready = g1;

    always_ff @(posedge clk_27mhz) begin
        if (reset) begin
            cnt            <= '0;
            pref           <= 1'b0;
            staging        <= '0;
            fetch_grant    <= 2'b00;
            audio_data_out <= '0;
            grant          <= 2'b00;
            frame_tick     <= 1'b0;
            underrun_cnt   <= 16'd0;
        end else begin
            cnt        <= active ? ((cnt == LOAD_CNT) ? '0 : cnt + CW'(1)) : '0;
            frame_tick <= load;
            if (fetch) begin
                fetch_grant <= {g1, g0};
                staging     <= g0 ? src0.data : g1 ? src1.data : HOLD_LAST ? staging : '0;
                if (g0 || g1)
                    pref <= g0;
                else if (underrun_cnt != 16'hFFFF)
                    underrun_cnt <= underrun_cnt + 16'd1;
            end
            if (load) begin
                audio_data_out <= out_n;
                grant          <= fetch_grant;
            end
        end
    end

`ifdef SOFT_MUTE_EN
    logic [4:0] atten, atten_n;
    // the attenuation applied at a frame boundary is the already-stepped value
    always_comb begin
        atten_n = mute ? ((atten == 5'd16) ? atten : atten + 5'd1)
                       : ((atten == 5'd0) ? atten : atten - 5'd1);
        out_n   = (atten_n == 5'd16) ? '0 : $unsigned($signed(staging) >>> atten_n);
    end

    always_ff @(posedge clk_27mhz) begin
        if (reset)
            atten <= 5'd0;
        else if (load)
            atten <= atten_n;
    end
`else
    always_comb out_n = mute ? '0 : staging;
`endif
endmodule

// File: tb/tb_audio_src_scheduler.sv
// tb_audio_src_scheduler: table vectors, hand corner sequences and random traffic against a frame-level model.
module tb_audio_src_scheduler;
    localparam int F = 8;
    logic clk_27mhz = 1'b0;
    logic reset = 1'b1, enable = 1'b0, mute = 1'b0;
    always #5 clk_27mhz = ~clk_27mhz;

    audio_src_if #(.DATA_W(16)) s0 (), s1 (), z0 (), z1 ();
    assign z0.valid = s0.valid;
    assign z0.data  = s0.data;
    assign z1.valid = s1.valid;
    assign z1.data  = s1.data;

    logic [15:0] out_a, out_b, ucnt_a, ucnt_b;
    logic        tick_a, tick_b;
    logic [1:0]  gr_a, gr_b;

    audio_src_scheduler #(.FRAME_CYCLES(F), .DATA_W(16), .HOLD_LAST(1'b1)) dut (
        .clk_27mhz(clk_27mhz), .reset(reset), .enable(enable), .mute(mute),
        .src0(s0), .src1(s1), .audio_data_out(out_a), .frame_tick(tick_a),
        .grant(gr_a), .underrun_cnt(ucnt_a));

    audio_src_scheduler #(.FRAME_CYCLES(F), .DATA_W(16), .HOLD_LAST(1'b0)) dut_z (
        .clk_27mhz(clk_27mhz), .reset(reset), .enable(enable), .mute(mute),
        .src0(z0), .src1(z1), .audio_data_out(out_b), .frame_tick(tick_b),
        .grant(gr_b), .underrun_cnt(ucnt_b));

    int vectors = 0, miscompares = 0;

    // frame-level model: index 1 follows HOLD_LAST=1, index 0 follows HOLD_LAST=0
    logic        m_run = 1'b0, m_pref = 1'b0, m_tick = 1'b0, acc0 = 1'b0, acc1 = 1'b0;
    int          m_pos = 0, m_ucnt = 0, m_atten = 0;
    logic [1:0]  m_fg = 2'b00, m_gr = 2'b00;
    logic [15:0] m_stg [2] = '{16'h0, 16'h0};
    logic [15:0] m_out [2] = '{16'h0, 16'h0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_pick();
        if (!(m_run && enable && m_pos == F - 2)) return 2'b00;
        if (s0.valid && s1.valid) return m_pref ? 2'b10 : 2'b01;
        return {s1.valid, s0.valid};
    endfunction

    task automatic model_update();
        logic [1:0] g;
        logic act;
        g = m_pick();
        acc0 = g[0];
        acc1 = g[1];
        if (reset) begin
            m_run = 0; m_pos = 0; m_pref = 0; m_fg = 0; m_gr = 0; m_tick = 0;
            m_ucnt = 0; m_atten = 0; acc0 = 0; acc1 = 0;
            m_stg = '{16'h0, 16'h0};
            m_out = '{16'h0, 16'h0};
        end else begin
            act = m_run && enable;
            m_tick = act && m_pos == F - 1;
            if (act && m_pos == F - 2) begin
                m_fg = g;
                if (g != 2'b00) begin
                    m_stg[1] = g[0] ? s0.data : s1.data;
                    m_stg[0] = m_stg[1];
                    m_pref = g[0];
                end else begin
                    m_stg[0] = 16'h0;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end
            if (m_tick) begin
                m_gr = m_fg;
`ifdef SOFT_MUTE_EN
                m_atten = mute ? ((m_atten < 16) ? m_atten + 1 : 16) : ((m_atten > 0) ? m_atten - 1 : 0);
                for (int h = 0; h < 2; h++)
                    m_out[h] = (m_atten == 16) ? 16'h0 : 16'($signed(m_stg[h]) >>> m_atten);
`else
                for (int h = 0; h < 2; h++)
                    m_out[h] = mute ? 16'h0 : m_stg[h];
`endif
            end
            m_pos = act ? (m_pos + 1) % F : 0;
            m_run = enable;
        end
    endtask

    // called at a negedge with inputs already driven; returns at the following negedge
    task automatic step();
        logic [1:0] g;
        #2;
        g = m_pick();
        chk("src0_ready", s0.ready, g[0]);
        chk("src1_ready", s1.ready, g[1]);
        chk("src0_ready_h0", z0.ready, g[0]);
        chk("src1_ready_h0", z1.ready, g[1]);
        @(posedge clk_27mhz);
        model_update();
        #1;
        chk("out_h1", out_a, m_out[1]);
        chk("out_h0", out_b, m_out[0]);
        chk("tick", tick_a, m_tick);
        chk("tick_h0", tick_b, m_tick);
        chk("grant", gr_a, m_gr);
        chk("grant_h0", gr_b, m_gr);
        chk("ucnt", ucnt_a, 32'(m_ucnt));
        chk("ucnt_h0", ucnt_b, 32'(m_ucnt));
        @(negedge clk_27mhz);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_a && n < 3 * F);
        if (!tick_a) chk("tick_timeout", tick_a, 1);
    endtask

    typedef struct {
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        logic [15:0] o1;
        logic [15:0] o0;
        logic [1:0]  g;
        logic [15:0] u;
    } vec_t;
    vec_t tbl [11];

    initial begin
        int n;
        logic signed [15:0] sm;
        tbl[0]  = '{1'b1, 16'h1234, 1'b0, 16'h0000, 16'h1234, 16'h1234, 2'b01, 16'd0};
        tbl[1]  = '{1'b1, 16'h0AAA, 1'b1, 16'h0BBB, 16'h0BBB, 16'h0BBB, 2'b10, 16'd0};
        tbl[2]  = '{1'b1, 16'h0AAA, 1'b1, 16'h0BBB, 16'h0AAA, 16'h0AAA, 2'b01, 16'd0};
        tbl[3]  = '{1'b1, 16'h0AAA, 1'b1, 16'h0BBB, 16'h0BBB, 16'h0BBB, 2'b10, 16'd0};
        tbl[4]  = '{1'b1, 16'h0AAA, 1'b1, 16'h0BBB, 16'h0AAA, 16'h0AAA, 2'b01, 16'd0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 16'h7000, 16'h7000, 16'h7000, 2'b10, 16'd0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h7000, 16'h0000, 2'b00, 16'd1};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h7000, 16'h0000, 2'b00, 16'd2};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h7000, 16'h0000, 2'b00, 16'd3};
        tbl[9]  = '{1'b1, 16'h5555, 1'b0, 16'h0000, 16'h5555, 16'h5555, 2'b01, 16'd3};
        tbl[10] = '{1'b1, 16'h0AAA, 1'b1, 16'h8001, 16'h8001, 16'h8001, 2'b10, 16'd3};
        s0.valid = 1'b0; s0.data = 16'h0; s1.valid = 1'b0; s1.data = 16'h0;
        repeat (3) @(posedge clk_27mhz);
        model_update();
        @(negedge clk_27mhz);
        chk("rst_out", out_a, 0);
        chk("rst_tick", tick_a, 0);
        chk("rst_grant", gr_a, 0);
        chk("rst_ucnt", ucnt_a, 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            s0.valid = tbl[i].v0; s0.data = tbl[i].d0;
            s1.valid = tbl[i].v1; s1.data = tbl[i].d1;
            enable = 1'b1;
            wait_tick(n);
            chk("tbl_out_h1", out_a, tbl[i].o1);
            chk("tbl_out_h0", out_b, tbl[i].o0);
            chk("tbl_grant", gr_a, tbl[i].g);
            chk("tbl_ucnt", ucnt_a, tbl[i].u);
        end

        // enable dropped mid-frame: output held, no ready, no tick; restart latency
        repeat (3) step();
        enable = 1'b0;
        repeat (12) begin
            step();
            chk("idle_tick", tick_a, 0);
            chk("idle_out", out_a, 16'h8001);
            chk("idle_ready", {s1.ready, s0.ready}, 0);
        end
        enable = 1'b1;
        wait_tick(n);
        chk("reenable_latency", n, 9);

        // reset in the LOAD cycle after src1 was captured
        s0.valid = 1'b0;
        s1.valid = 1'b1; s1.data = 16'h1357;
        repeat (7) step();
        reset = 1'b1;
        step();
        chk("midrst_out", out_a, 0);
        chk("midrst_tick", tick_a, 0);
        chk("midrst_grant", gr_a, 0);
        chk("midrst_ucnt", ucnt_a, 0);
        reset = 1'b0;

`ifdef SOFT_MUTE_EN
        s0.valid = 1'b1; s0.data = 16'h4000; s1.valid = 1'b0;
        mute = 1'b1;
        sm = 16'sh4000;
        for (int k = 1; k <= 16; k++) begin
            wait_tick(n);
            chk("ramp_down", out_a, (k == 16) ? 16'h0 : 16'(sm >>> k));
        end
        mute = 1'b0;
        for (int k = 15; k >= 10; k--) begin
            wait_tick(n);
            chk("ramp_up", out_a, 16'(sm >>> k));
        end
`endif

        mute = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(63) == 0) enable = ~enable;
            if ($urandom_range(47) == 0) mute = ~mute;
            if (!s0.valid || acc0) begin
                s0.valid = $urandom_range(2) != 0;
                s0.data = 16'($urandom);
            end
            if (!s1.valid || acc1) begin
                s1.valid = $urandom_range(2) != 0;
                s1.data = 16'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
